// File: rtl/coin_field_controller.sv
// coin_field_controller: owns the 15x20 coin grid, fill sweep, collision clears,
// coin count and score. Define COIN_FIELD_POWER_PELLET_EN for 2-bit pellet cells.
module coin_field_controller #(
    parameter int ROWS        = 15,
    parameter int COLS        = 20,
    parameter int COIN_POINTS = 10,
    parameter int SCORE_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_level,
    input  logic               col_req,
    input  logic [3:0]         col_row,
    input  logic [4:0]         col_col,
    output logic               col_ack,
    output logic               coin_eaten,
    output logic               pellet_eaten,
    input  logic [3:0]         rd_row,
    input  logic [4:0]         rd_col,
    output logic               rd_coin,
    output logic               rd_pellet,
    output logic [8:0]         coins_left,
    output logic [SCORE_W-1:0] score,
    output logic               level_cleared,
    output logic               busy
);

    localparam int CELLS = ROWS * COLS;
`ifdef COIN_FIELD_POWER_PELLET_EN
    localparam int CW = 2;
`else
    localparam int CW = 1;
`endif
    localparam logic [3:0]         ROW_LIM  = 4'(ROWS);
    localparam logic [4:0]         COL_LIM  = 5'(COLS);
    localparam logic [CW-1:0]      C_EMPTY  = '0;
    localparam logic [CW-1:0]      C_COIN   = CW'(1);
`ifdef COIN_FIELD_POWER_PELLET_EN
    localparam logic [CW-1:0]      C_PELLET = CW'(2);
    localparam logic [SCORE_W-1:0] PEL_PTS  = SCORE_W'(50);
`endif
    localparam logic [SCORE_W-1:0] COIN_PTS = SCORE_W'(COIN_POINTS);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_CLEARED
    } state_t;

    function automatic logic in_grid(logic [3:0] r, logic [4:0] c);
        return (r < ROW_LIM) && (c < COL_LIM);
    endfunction

    function automatic logic [8:0] cell_idx(logic [3:0] r, logic [4:0] c);
        return 9'(r) * 9'(COLS) + 9'(c);
    endfunction

    // Level layout: 13x18 block of coins with a hole at (5,8).
    function automatic logic [CW-1:0] fill_code(logic [3:0] r, logic [4:0] c);
        if (r > 4'd12 || c > 5'd17 || (r == 4'd5 && c == 5'd8)) begin
            return C_EMPTY;
        end
`ifdef COIN_FIELD_POWER_PELLET_EN
        if ((r == 4'd0 || r == 4'd12) && (c == 5'd0 || c == 5'd17)) begin
            return C_PELLET;
        end
`endif
        return C_COIN;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(logic [SCORE_W-1:0] s,
                                                   logic [SCORE_W-1:0] p);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + {1'b0, p};
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

    state_t               state_q, state_d;
    logic [3:0]           fill_row_q, fill_row_d;
    logic [4:0]           fill_col_q, fill_col_d;
    logic [8:0]           coins_q, coins_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 ack_q, ack_d;
    logic                 eaten_q, eaten_d;
    logic                 pel_q, pel_d;
    logic                 armed_q, armed_d;
    logic                 rd_coin_q, rd_coin_d;
    logic                 rd_pel_q, rd_pel_d;
    logic [CW-1:0]        grid_q [CELLS];
    logic [CW-1:0]        grid_d [CELLS];

    logic [8:0]           fill_idx, col_idx, rd_idx;
    logic [CW-1:0]        fill_cell, col_cell, rd_cell;

    assign fill_idx  = cell_idx(fill_row_q, fill_col_q);
    assign col_idx   = cell_idx(col_row, col_col);
    assign rd_idx    = cell_idx(rd_row, rd_col);
    assign fill_cell = fill_code(fill_row_q, fill_col_q);
    assign col_cell  = in_grid(col_row, col_col) ? grid_q[col_idx] : C_EMPTY;
    assign rd_cell   = in_grid(rd_row, rd_col) ? grid_q[rd_idx] : C_EMPTY;

    // Next state: fill sweep, collision service (armed only after a low cycle), read port.
    always_comb begin
        state_d    = state_q;
        fill_row_d = fill_row_q;
        fill_col_d = fill_col_q;
        coins_d    = coins_q;
        score_d    = score_q;
        grid_d     = grid_q;
        ack_d      = 1'b0;
        eaten_d    = 1'b0;
        pel_d      = 1'b0;
        armed_d    = armed_q | ~col_req;
        if (new_level) begin
            state_d    = S_FILL;
            fill_row_d = '0;
            fill_col_d = '0;
            coins_d    = '0;
        end else begin
            unique case (state_q)
                S_FILL: begin
                    grid_d[fill_idx] = fill_cell;
                    if (fill_cell != C_EMPTY) begin
                        coins_d = coins_q + 9'd1;
                    end
                    if (fill_col_q == COL_LIM - 5'd1) begin
                        fill_col_d = '0;
                        if (fill_row_q == ROW_LIM - 4'd1) begin
                            fill_row_d = '0;
                            state_d    = S_RUN;
                        end else begin
                            fill_row_d = fill_row_q + 4'd1;
                        end
                    end else begin
                        fill_col_d = fill_col_q + 5'd1;
                    end
                end
                S_RUN: begin
                    if (coins_q == '0) begin
                        state_d = S_CLEARED;
                    end else if (col_req && armed_q) begin
                        ack_d   = 1'b1;
                        armed_d = 1'b0;
                        if (col_cell == C_COIN) begin
                            grid_d[col_idx] = C_EMPTY;
                            coins_d = coins_q - 9'd1;
                            score_d = sat_add(score_q, COIN_PTS);
                            eaten_d = 1'b1;
                        end
`ifdef COIN_FIELD_POWER_PELLET_EN
                        else if (col_cell == C_PELLET) begin
                            grid_d[col_idx] = C_EMPTY;
                            coins_d = coins_q - 9'd1;
                            score_d = sat_add(score_q, PEL_PTS);
                            pel_d   = 1'b1;
                        end
`endif
                    end
                end
                S_CLEARED: begin
                    if (col_req && armed_q) begin
                        ack_d   = 1'b1;
                        armed_d = 1'b0;
                    end
                end
                default: state_d = S_FILL;
            endcase
        end
        rd_coin_d = (state_d == S_RUN) && (rd_cell == C_COIN);
`ifdef COIN_FIELD_POWER_PELLET_EN
        rd_pel_d  = (state_d == S_RUN) && (rd_cell == C_PELLET);
`else
        rd_pel_d  = 1'b0;
`endif
    end

    // State, grid and output registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FILL;
            fill_row_q <= '0;
            fill_col_q <= '0;
            coins_q    <= '0;
            score_q    <= '0;
            ack_q      <= 1'b0;
            eaten_q    <= 1'b0;
            pel_q      <= 1'b0;
            armed_q    <= 1'b1;
            rd_coin_q  <= 1'b0;
            rd_pel_q   <= 1'b0;
            for (int i = 0; i < CELLS; i++) begin
                grid_q[i] <= C_EMPTY;
            end
        end else begin
            state_q    <= state_d;
            fill_row_q <= fill_row_d;
            fill_col_q <= fill_col_d;
            coins_q    <= coins_d;
            score_q    <= score_d;
            ack_q      <= ack_d;
            eaten_q    <= eaten_d;
            pel_q      <= pel_d;
            armed_q    <= armed_d;
            rd_coin_q  <= rd_coin_d;
            rd_pel_q   <= rd_pel_d;
            grid_q     <= grid_d;
        end
    end

    assign col_ack       = ack_q;
    assign coin_eaten    = eaten_q;
    assign pellet_eaten  = pel_q;
    assign rd_coin       = rd_coin_q;
    assign rd_pellet     = rd_pel_q;
    assign coins_left    = coins_q;
    assign score         = score_q;
    assign level_cleared = (state_q == S_CLEARED);
    assign busy          = (state_q == S_FILL);

endmodule

// File: tb/tb_coin_field_controller.sv
// tb_coin_field_controller: random and directed stimulus against a grid model
// built from the level layout, scoring and count rules.
module tb_coin_field_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_level = 1'b0;
    logic        col_req = 1'b0;
    logic [3:0]  col_row = '0;
    logic [4:0]  col_col = '0;
    logic        col_ack, coin_eaten, pellet_eaten;
    logic [3:0]  rd_row = '0;
    logic [4:0]  rd_col = '0;
    logic        rd_coin, rd_pellet;
    logic [8:0]  coins_left;
    logic [15:0] score;
    logic        level_cleared, busy;

    int total = 0;
    int bad = 0;

    int mg [15][20];
    int m_coins;
    int m_score;

    always #5 clk = ~clk;

    coin_field_controller dut (
        .clk(clk), .reset(reset), .new_level(new_level),
        .col_req(col_req), .col_row(col_row), .col_col(col_col),
        .col_ack(col_ack), .coin_eaten(coin_eaten), .pellet_eaten(pellet_eaten),
        .rd_row(rd_row), .rd_col(rd_col), .rd_coin(rd_coin), .rd_pellet(rd_pellet),
        .coins_left(coins_left), .score(score),
        .level_cleared(level_cleared), .busy(busy)
    );

    function automatic int pattern(int r, int c);
        if (r > 12 || c > 17 || (r == 5 && c == 8)) return 0;
`ifdef COIN_FIELD_POWER_PELLET_EN
        if ((r == 0 || r == 12) && (c == 0 || c == 17)) return 2;
`endif
        return 1;
    endfunction

    function automatic void model_fill();
        m_coins = 0;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++) begin
                mg[r][c] = pattern(r, c);
                if (mg[r][c] != 0) m_coins++;
            end
    endfunction

    function automatic int model_peek(int r, int c);
        if (r < 15 && c < 20) return mg[r][c];
        return 0;
    endfunction

    function automatic int model_eat(int r, int c);
        int code;
        code = model_peek(r, c);
        if (code != 0) begin
            mg[r][c] = 0;
            m_coins--;
            m_score += (code == 2) ? 50 : 10;
            if (m_score > 65535) m_score = 65535;
        end
        return code;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fill(output int n);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            step();
        end
    endtask

    task automatic do_read(input int r, input int c, output logic coin, output logic pel);
        rd_row = 4'(r);
        rd_col = 5'(c);
        step();
        coin = rd_coin;
        pel  = rd_pellet;
    endtask

    task automatic do_col(input int r, input int c, input int max_wait,
                          output logic ack, output logic eat, output logic peat,
                          output logic rd_pre, output logic rdp_pre,
                          output logic rd_post, output logic reack);
        int waited;
        col_row = 4'(r);
        col_col = 5'(c);
        rd_row  = 4'(r);
        rd_col  = 5'(c);
        col_req = 1'b1;
        waited  = 0;
        do begin
            step();
            waited++;
        end while (col_ack !== 1'b1 && waited < max_wait);
        ack     = col_ack;
        eat     = coin_eaten;
        peat    = pellet_eaten;
        rd_pre  = rd_coin;
        rdp_pre = rd_pellet;
        step();
        col_req = 1'b0;
        rd_post = rd_coin;
        reack   = col_ack;
        step();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step();
        total++;
        if ({busy, level_cleared, col_ack, coin_eaten, pellet_eaten, rd_coin, rd_pellet} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 1000000",
                     {busy, level_cleared, col_ack, coin_eaten, pellet_eaten, rd_coin, rd_pellet});
        end
        total++;
        if (coins_left !== 9'd0 || score !== 16'd0) begin
            bad++;
            $display("FAIL reset_counts: coins=%0d score=%0d want 0 0", coins_left, score);
        end
        reset = 1'b0;
        m_score = 0;
    endtask

    task automatic test_fill;
        int n;
        int rt[6];
        int ct[6];
        logic coin, pel;
        rt = '{0, 5, 13, 2, 12, 3};
        ct = '{0, 8, 3, 18, 17, 4};
        model_fill();
        wait_fill(n);
        total++;
        if (n != 300) begin
            bad++;
            $display("FAIL fill_busy_cycles: got %0d want 300", n);
        end
        total++;
        if (coins_left !== 9'(m_coins) || m_coins != 233) begin
            bad++;
            $display("FAIL fill_coins: got %0d want 233", coins_left);
        end
        for (int i = 0; i < 6; i++) begin
            do_read(rt[i], ct[i], coin, pel);
            total++;
            if (coin !== 1'(mg[rt[i]][ct[i]] == 1) || pel !== 1'(model_peek(rt[i], ct[i]) == 2)) begin
                bad++;
                $display("FAIL fill_read(%0d,%0d): got coin=%b pel=%b want cell=%0d",
                         rt[i], ct[i], coin, pel, model_peek(rt[i], ct[i]));
            end
        end
    endtask

    task automatic test_collisions;
        int rt[5];
        int ct[5];
        int pre, code;
        logic ack, eat, peat, rpre, rppre, rpost, reack;
        rt = '{3, 3, 5, 14, 15};
        ct = '{4, 4, 8, 19, 21};
        for (int i = 0; i < 5; i++) begin
            pre  = model_peek(rt[i], ct[i]);
            code = model_eat(rt[i], ct[i]);
            do_col(rt[i], ct[i], 4, ack, eat, peat, rpre, rppre, rpost, reack);
            total++;
            if (ack !== 1'b1 || reack !== 1'b0) begin
                bad++;
                $display("FAIL col_ack(%0d,%0d): got ack=%b reack=%b want 1 0", rt[i], ct[i], ack, reack);
            end
            total++;
            if (eat !== 1'(code == 1) || peat !== 1'(code == 2)) begin
                bad++;
                $display("FAIL col_eaten(%0d,%0d): got %b%b want code %0d", rt[i], ct[i], eat, peat, code);
            end
            total++;
            if (rpre !== 1'(pre == 1) || rpost !== 1'b0) begin
                bad++;
                $display("FAIL col_read(%0d,%0d): got pre=%b post=%b want %b 0",
                         rt[i], ct[i], rpre, rpost, 1'(pre == 1));
            end
            total++;
            if (coins_left !== 9'(m_coins) || score !== 16'(m_score)) begin
                bad++;
                $display("FAIL col_counts(%0d,%0d): got %0d/%0d want %0d/%0d",
                         rt[i], ct[i], coins_left, score, m_coins, m_score);
            end
        end
    endtask

    task automatic test_random;
        int r, c, code;
        logic coin, pel, ack, eat, peat, rpre, rppre, rpost, reack;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(15, 0);
            c = $urandom_range(21, 0);
            if ($urandom_range(1, 0) == 0) begin
                do_read(r, c, coin, pel);
                total++;
                if (coin !== 1'(model_peek(r, c) == 1) || pel !== 1'(model_peek(r, c) == 2)) begin
                    bad++;
                    $display("FAIL rand_read(%0d,%0d): got %b%b want cell %0d", r, c, coin, pel, model_peek(r, c));
                end
            end else begin
                code = model_eat(r, c);
                do_col(r, c, 4, ack, eat, peat, rpre, rppre, rpost, reack);
                total++;
                if (ack !== 1'b1 || eat !== 1'(code == 1) || peat !== 1'(code == 2)
                    || coins_left !== 9'(m_coins) || score !== 16'(m_score)) begin
                    bad++;
                    $display("FAIL rand_col(%0d,%0d): ack=%b eat=%b%b coins=%0d score=%0d want code %0d %0d/%0d",
                             r, c, ack, eat, peat, coins_left, score, code, m_coins, m_score);
                end
            end
        end
    endtask

    task automatic test_eat_all;
        int code;
        logic ack, eat, peat, rpre, rppre, rpost, reack, coin, pel;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++)
                if (mg[r][c] != 0) begin
                    code = model_eat(r, c);
                    do_col(r, c, 4, ack, eat, peat, rpre, rppre, rpost, reack);
                    total++;
                    if (ack !== 1'b1 || eat !== 1'(code == 1) || peat !== 1'(code == 2)) begin
                        bad++;
                        $display("FAIL eat_all(%0d,%0d): ack=%b eat=%b%b want code %0d", r, c, ack, eat, peat, code);
                    end
                end
        total++;
        if (coins_left !== 9'd0 || score !== 16'(m_score) || level_cleared !== 1'b1) begin
            bad++;
            $display("FAIL eat_all_end: coins=%0d score=%0d lc=%b want 0 %0d 1", coins_left, score, level_cleared, m_score);
        end
`ifndef COIN_FIELD_POWER_PELLET_EN
        total++;
        if (score !== 16'd2330) begin
            bad++;
            $display("FAIL eat_all_score: got %0d want 2330", score);
        end
`endif
        do_col(3, 4, 4, ack, eat, peat, rpre, rppre, rpost, reack);
        total++;
        if (ack !== 1'b1 || eat !== 1'b0 || score !== 16'(m_score) || level_cleared !== 1'b1) begin
            bad++;
            $display("FAIL cleared_col: ack=%b eat=%b score=%0d lc=%b", ack, eat, score, level_cleared);
        end
        do_read(0, 0, coin, pel);
        total++;
        if (coin !== 1'b0) begin
            bad++;
            $display("FAIL cleared_read: got %b want 0", coin);
        end
    endtask

    task automatic test_new_level;
        int n, fillcyc, code;
        col_row   = 4'd3;
        col_col   = 5'd4;
        col_req   = 1'b1;
        new_level = 1'b1;
        step();
        new_level = 1'b0;
        model_fill();
        code = model_eat(3, 4);
        n = 0;
        fillcyc = 0;
        while (col_ack !== 1'b1 && n < 400) begin
            if (busy === 1'b1) fillcyc++;
            step();
            n++;
        end
        total++;
        if (col_ack !== 1'b1 || busy !== 1'b0 || fillcyc != 300) begin
            bad++;
            $display("FAIL newlvl_ack: ack=%b busy=%b fill=%0d want 1 0 300", col_ack, busy, fillcyc);
        end
        total++;
        if (coin_eaten !== 1'(code == 1) || coins_left !== 9'(m_coins) || score !== 16'(m_score)) begin
            bad++;
            $display("FAIL newlvl_counts: eat=%b coins=%0d score=%0d want %0d/%0d",
                     coin_eaten, coins_left, score, m_coins, m_score);
        end
        step();
        col_req = 1'b0;
        step();
    endtask

    task automatic test_pending_fill;
        int n;
        logic coin, pel;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_score = 0;
        model_fill();
        repeat (10) step();
        col_row = 4'd7;
        col_col = 5'd9;
        col_req = 1'b1;
        n = 0;
        while (col_ack !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        void'(model_eat(7, 9));
        total++;
        if (col_ack !== 1'b1 || busy !== 1'b0 || coin_eaten !== 1'b1) begin
            bad++;
            $display("FAIL pend_ack: ack=%b busy=%b eat=%b want 1 0 1", col_ack, busy, coin_eaten);
        end
        total++;
        if (coins_left !== 9'(m_coins) || score !== 16'd10) begin
            bad++;
            $display("FAIL pend_counts: coins=%0d score=%0d want %0d 10", coins_left, score, m_coins);
        end
        step();
        col_req = 1'b0;
        do_read(7, 9, coin, pel);
        total++;
        if (coin !== 1'b0) begin
            bad++;
            $display("FAIL pend_cell: got %b want 0", coin);
        end
    endtask

    task automatic test_reset_mid_fill;
        int exp;
        new_level = 1'b1;
        step();
        new_level = 1'b0;
        repeat (50) step();
        exp = 0;
        for (int i = 0; i < 50; i++)
            if (pattern(i / 20, i % 20) != 0) exp++;
        total++;
        if (busy !== 1'b1 || coins_left !== 9'(exp)) begin
            bad++;
            $display("FAIL midfill_progress: busy=%b coins=%0d want 1 %0d", busy, coins_left, exp);
        end
        reset = 1'b1;
        step();
        total++;
        if ({busy, level_cleared, col_ack, coin_eaten, pellet_eaten, rd_coin, rd_pellet} !== 7'b1000000
            || coins_left !== 9'd0 || score !== 16'd0) begin
            bad++;
            $display("FAIL midfill_reset: flags=%b coins=%0d score=%0d",
                     {busy, level_cleared, col_ack, coin_eaten, pellet_eaten, rd_coin, rd_pellet},
                     coins_left, score);
        end
        reset = 1'b0;
        m_score = 0;
    endtask

`ifdef COIN_FIELD_POWER_PELLET_EN
    task automatic test_pellet;
        int n;
        logic ack, eat, peat, rpre, rppre, rpost, reack;
        model_fill();
        wait_fill(n);
        do_col(0, 0, 4, ack, eat, peat, rpre, rppre, rpost, reack);
        total++;
        if (ack !== 1'b1 || peat !== 1'b1 || eat !== 1'b0 || rpre !== 1'b0 || rppre !== 1'b1) begin
            bad++;
            $display("FAIL pellet_flags: ack=%b peat=%b eat=%b rd=%b%b", ack, peat, eat, rpre, rppre);
        end
        total++;
        if (score !== 16'd50 || coins_left !== 9'd232) begin
            bad++;
            $display("FAIL pellet_counts: score=%0d coins=%0d want 50 232", score, coins_left);
        end
    endtask
`endif

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_collisions();
        test_random();
        test_eat_all();
        test_new_level();
        test_pending_fill();
        test_reset_mid_fill();
`ifdef COIN_FIELD_POWER_PELLET_EN
        test_pellet();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_field_controller.md
Name: coin_field_controller

Overview:
- Owns the 15x20 coin-occupancy grid that the coin bitmap renderer draws from.
- Sequences the grid: fills it after reset or a new level, clears cells on pacman/coin collisions, counts remaining coins and accumulates score.
- Arbitrates between the renderer read port, collision clear requests and the level-refill sweep.
- Raises level_cleared when the last coin is eaten.

Parameters:
- ROWS, 15, grid rows (tile = 32x32 px).
- COLS, 20, grid columns.
- COIN_POINTS, 10, score added per coin eaten.
- SCORE_W, 16, score accumulator width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- new_level  in  1  one-cycle pulse; restarts the fill sweep.
- col_req  in  1  collision clear request; held high until col_ack.
- col_row  in  4  collision tile row (pixel offsetY[8:5]).
- col_col  in  5  collision tile column (pixel offsetX[9:5]).
- col_ack  out  1  one-cycle pulse; request consumed.
- coin_eaten  out  1  one-cycle pulse, coincident with col_ack, when a coin was actually removed.
- rd_row  in  4  renderer read row.
- rd_col  in  5  renderer read column.
- rd_coin  out  1  cell holds a coin; valid 1 cycle after rd_row/rd_col.
- coins_left  out  9  remaining coin count.
- score  out  SCORE_W  accumulated score.
- level_cleared  out  1  level-high while in CLEARED.
- busy  out  1  high while in FILL.

Behaviour:
- Reset (dominates every other input):
  - state=FILL, fill index=0, all cells=0.
  - coins_left=0, score=0, col_ack=0, coin_eaten=0, rd_coin=0, level_cleared=0, busy=1.
- Default pattern:
  - coin in rows 0..12, cols 0..17, except cell (5,8).
  - All other cells empty.
  - Total = 233 coins.
- FILL:
  - Writes one cell per cycle, row-major, index 0..ROWS*COLS-1; takes 300 cycles.
  - coins_left increments for each coin written.
  - After writing index 299, state goes to RUN next cycle (coins_left=233).
  - col_req is not acknowledged in FILL; it stays pending.
  - rd_coin is forced 0 throughout FILL.
- RUN:
  - A pending col_req is serviced in the cycle it is seen; col_ack pulses on the next cycle.
  - If the cell holds a coin: cell cleared, coins_left-1, score+COIN_POINTS, coin_eaten pulses with col_ack.
  - If the cell is empty or out of range (row>=ROWS or col>=COLS): col_ack only, no state change.
  - Requester drops col_req the cycle after col_ack. A request still high on the ack cycle is not re-serviced; the controller requires one low cycle between requests.
  - When coins_left reaches 0, state goes to CLEARED on the cycle following the final coin_eaten.
- CLEARED:
  - level_cleared=1.
  - col_req is acked with no effect.
  - rd_coin reads 0 for every cell.
- new_level:
  - In any state, new_level sends the controller to FILL with index=0 and coins_left=0.
  - score is retained.
  - new_level beats a same-cycle col_req; that request stays pending and is acked after FILL.
- Renderer read port:
  - Independent of writes; rd_coin is a registered read, 1-cycle latency.
  - A read of the cell being cleared in the same cycle returns the pre-clear value. The new value is visible one cycle later.
  - Out-of-range read returns 0.
- score saturates at all-ones and does not wrap.
- coins_left never underflows; a decrement happens only on a real coin removal.

Optional Feature:
- Macro: COIN_FIELD_POWER_PELLET_EN.
- When defined:
  - Cells use a 2-bit code: 00 empty, 01 coin, 10 pellet.
  - Cells (0,0), (0,17), (12,0), (12,17) fill as pellets instead of coins; the total is still 233 items.
  - Extra output rd_pellet (1 bit) has the same timing as rd_coin.
  - Eating a pellet: cell cleared, coins_left-1, score+50, and extra output pellet_eaten (1 bit) pulses with col_ack. coin_eaten stays 0 for pellets.
- When undefined:
  - 1-bit cells; rd_pellet and pellet_eaten exist and are tied 0.

Test Plan:
- Reset, then idle 301 cycles -> busy=1 for 300 cycles, then 0; coins_left=233; rd (0,0)=1; rd (5,8)=0; rd (13,3)=0; rd (2,18)=0.
- In RUN, col_req (3,4) -> col_ack and coin_eaten 1 cycle later; coins_left=232; score=10; repeat (3,4) -> col_ack only, score stays 10.
- col_req (5,8) and col_req (14,19) -> col_ack, no coin_eaten; col_req (15,21) out of range -> ack, no change, no X.
- col_req asserted during FILL at cycle 10 -> no col_ack until RUN entry, then ack; the cell it targeted is cleared; coins_left=232.
- Eat all 233 coins -> score=2330, coins_left=0, level_cleared=1; new_level -> FILL, score=2330 retained, coins_left returns to 233.
- With COIN_FIELD_POWER_PELLET_EN, eat (0,0) -> pellet_eaten=1, coin_eaten=0, score=50, coins_left=232; reset asserted mid-FILL -> all outputs return to reset values next cycle.
